bram_add_seq: RTL and testbench
===============================

BRAM_ADD_SEQ -- requirements
Module: bram_add_seq

Interface
REQ-001 Parameter BASE_A, default 32'h0000_0000: byte base address of operand-A region in BRAM A.
REQ-002 Parameter BASE_B, default 32'h0000_1000: byte base address of operand-B region in BRAM B.
REQ-003 Parameter BASE_C, default 32'h0000_2000: byte base address of result region in BRAM C.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to process len words.
REQ-007 len  input  8  word count, sampled on accepted start.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 addr_a / addr_b  output  32 each  BRAM A / B read byte addresses.
REQ-011 dout_a / dout_b  input  32 each  BRAM A / B read data, valid one cycle after address.
REQ-012 op_a / op_b  output  32 each  registered operands to the downstream adder.
REQ-013 sum  input  32  combinational adder result of op_a + op_b.
REQ-014 addr_c  output  32  BRAM C write byte address.
REQ-015 din_c  output  32  BRAM C write data.
REQ-016 we_c  output  4  BRAM C byte write enables.

Function
REQ-017 FSM states SHALL be IDLE, READ, WAIT, CAPT, WRITE, FIN.
REQ-018 IDLE: start=1 with len!=0 -> READ, load count=len, index=0; start=1 with len=0 -> FIN.
REQ-019 READ: drive addr_a=BASE_A+4*index, addr_b=BASE_B+4*index; -> WAIT.
REQ-020 WAIT: hold addresses one cycle for BRAM read latency; -> CAPT.
REQ-021 CAPT: register op_a<=dout_a, op_b<=dout_b; -> WRITE.
REQ-022 WRITE: addr_c=BASE_C+4*index, din_c=sum, we_c=4'hF for exactly this cycle; index+1, count-1; count becomes 0 -> FIN, else -> READ.
REQ-023 FIN: done=1 for one cycle, busy=0 next cycle; -> IDLE.
REQ-024 Per-word latency SHALL be 4 cycles; total start-to-done = 4*len+1 cycles (len=0: 1 cycle).
REQ-025 start while busy SHALL be ignored; len changes while busy SHALL have no effect.
REQ-026 Index arithmetic SHALL be 8-bit, address offset = index zero-extended, shifted left 2, added modulo 2^32.
REQ-027 len=255 SHALL complete all 255 words with no index wrap.
REQ-028 we_c SHALL be 0 in every state other than WRITE.
REQ-029 busy SHALL be 1 in READ, WAIT, CAPT, WRITE, FIN.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, clear count, index, op_a, op_b, addr_a, addr_b, addr_c, din_c to 0, we_c=4'h0, busy=0, done=0.
REQ-031 Reset mid-operation SHALL abort without any further BRAM C write; no done pulse.
REQ-032 First start SHALL be accepted on the first rising edge after reset deassertion.

Configuration
REQ-033 Macro BRAM_ADD_SEQ_SKIP_ZERO_EN.
REQ-034 Defined: in WRITE, if op_a==0, we_c SHALL stay 4'h0 (word skipped); timing unchanged.
REQ-035 Undefined: every WRITE cycle asserts we_c=4'hF regardless of operand value.

Verification
REQ-036 len=1, A[0]=5, B[0]=7 -> one write addr_c=32'h2000, din_c=12, we_c=4'hF; done 5 cycles after start.
REQ-037 len=4, A={1,2,3,4}, B={10,20,30,40} -> writes 11,22,33,44 at 32'h2000..32'h200C, 4 cycles apart; done at cycle 17.
REQ-038 len=0 -> no write, done pulse one cycle after start, busy high for that cycle only.
REQ-039 start re-pulsed with len=9 during len=3 run -> exactly 3 writes, len=9 ignored.
REQ-040 reset=0 in WAIT of word 2 of len=4 -> all outputs 0 immediately, no further we_c, no done; new start afterwards runs cleanly from index 0.
REQ-041 With BRAM_ADD_SEQ_SKIP_ZERO_EN, A={0,3}, B={9,4} -> word 0 no write, word 1 writes 7 at 32'h2004; done at cycle 9.

Source files
------------

// File: rtl/bram_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : bram_add_seq
// Description : Sequential element-wise adder over BRAM regions. For each of
//               len words it reads A[i] and B[i], hands them to an external
//               combinational adder through registered operands, and writes
//               the sum to C[i]. Four cycles per word plus one finish cycle.
// Options     : BRAM_ADD_SEQ_SKIP_ZERO_EN - when defined, words whose
//               operand A is zero are not written to BRAM C.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_add_seq #(
    parameter logic [31:0] BASE_A = 32'h0000_0000,
    parameter logic [31:0] BASE_B = 32'h0000_1000,
    parameter logic [31:0] BASE_C = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic [31:0] addr_a,
    output logic [31:0] addr_b,
    input  logic [31:0] dout_a,
    input  logic [31:0] dout_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] sum,
    output logic [31:0] addr_c,
    output logic [31:0] din_c,
    output logic [3:0]  we_c
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

    logic [2:0]  state;
    logic [7:0]  count;
    logic [7:0]  index;
    logic [7:0]  index_next;
    logic [31:0] offset;
    logic [31:0] offset_next;

    // Byte offsets of the current and the following word (8-bit index, x4).
    assign index_next  = index + 8'd1;
    assign offset      = {22'd0, index, 2'b00};
    assign offset_next = {22'd0, index_next, 2'b00};

    // Status flags decode straight from the state so reset clears them at once.
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // Sequencer: state, word counters, read addresses and captured operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= 8'd0;
            index  <= 8'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            addr_a <= 32'd0;
            addr_b <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != 8'd0) begin
                            state  <= READ;
                            count  <= len;
                            index  <= 8'd0;
                            addr_a <= BASE_A;
                            addr_b <= BASE_B;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                READ: state <= WAIT;
                // Addresses stay put so the BRAM output is stable when captured.
                WAIT: state <= CAPT;
                CAPT: begin
                    op_a  <= dout_a;
                    op_b  <= dout_b;
                    state <= WRITE;
                end
                WRITE: begin
                    index <= index_next;
                    count <= count - 8'd1;
                    if (count == 8'd1) begin
                        state <= FIN;
                    end else begin
                        state  <= READ;
                        addr_a <= BASE_A + offset_next;
                        addr_b <= BASE_B + offset_next;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM C write port is only active during the WRITE cycle.
    always_comb begin
        addr_c = 32'd0;
        din_c  = 32'd0;
        we_c   = 4'h0;
        if (state == WRITE) begin
            addr_c = BASE_C + offset;
            din_c  = sum;
            we_c   = 4'hF;
`ifdef BRAM_ADD_SEQ_SKIP_ZERO_EN
            if (op_a == 32'd0) begin
                we_c = 4'h0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_add_seq
// Description : Self-checking bench for bram_add_seq. Models BRAM A/B with a
//               one-cycle read latency and the external adder; BRAM C writes
//               are checked against a queue of expected writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_add_seq;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_1000;
    localparam logic [31:0] BASE_C = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        busy, done;
    logic [31:0] addr_a, addr_b, dout_a, dout_b;
    logic [31:0] op_a, op_b, sum, addr_c, din_c;
    logic [3:0]  we_c;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t sb[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int done_cnt = 0;

    bram_add_seq #(.BASE_A(BASE_A), .BASE_B(BASE_B), .BASE_C(BASE_C)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .busy(busy), .done(done),
        .addr_a(addr_a), .addr_b(addr_b), .dout_a(dout_a), .dout_b(dout_b),
        .op_a(op_a), .op_b(op_b), .sum(sum),
        .addr_c(addr_c), .din_c(din_c), .we_c(we_c)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM A/B models: registered read, data one cycle after the address.
    always @(posedge clk) begin
        logic [31:0] wa, wb;
        wa = (addr_a - BASE_A) >> 2;
        wb = (addr_b - BASE_B) >> 2;
        dout_a <= mem_a[wa[7:0]];
        dout_b <= mem_b[wb[7:0]];
    end

    assign sum = op_a + op_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit skipped(input logic [31:0] a);
        bit en;
`ifdef BRAM_ADD_SEQ_SKIP_ZERO_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (a == 32'd0);
    endfunction

    // BRAM C monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (we_c !== 4'h0) begin
            if (sb.size() == 0) begin
                check("unexpected_write_we", {28'd0, we_c}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write_we",   {28'd0, we_c}, 32'hF);
                check("write_addr", addr_c, e.addr);
                check("write_data", din_c,  e.data);
                check("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One complete job: push expected writes, pulse start, wait for done.
    task automatic run(input logic [7:0] n, input bit restart);
        int s;
        int waited;
        @(negedge clk);
        s = cyc;
        for (int i = 0; i < int'(n); i++) begin
            if (!skipped(mem_a[i]))
                sb.push_back('{BASE_C + 32'(i * 4), mem_a[i] + mem_b[i], s + 4 * i + 4});
        end
        reset = 1'b1;
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        len   = 8'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (restart) begin
            start = 1'b1;
            len   = 8'd9;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (!done && waited < 1100) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_latency", 32'(cyc - s), 32'(4 * int'(n) + 1));
        @(negedge clk);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int s;
        int dc;
        reset = 1'b0;
        start = 1'b0;
        len   = 8'd0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        #1;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_addr_a", addr_a, 32'd0);
        check("rst_addr_b", addr_b, 32'd0);
        check("rst_op_a",   op_a,   32'd0);
        check("rst_op_b",   op_b,   32'd0);
        check("rst_addr_c", addr_c, 32'd0);
        check("rst_din_c",  din_c,  32'd0);
        check("rst_we_c",   {28'd0, we_c}, 32'd0);
        repeat (3) @(posedge clk);

        // len=1: 5 + 7, start on the first edge after reset release.
        mem_a[0] = 32'd5; mem_b[0] = 32'd7;
        run(8'd1, 1'b0);

        // len=4: four sums, four cycles apart.
        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'd4;
        mem_b[0] = 32'd10; mem_b[1] = 32'd20; mem_b[2] = 32'd30; mem_b[3] = 32'd40;
        run(8'd4, 1'b0);

        // len=0: finish pulse only.
        run(8'd0, 1'b0);

        // len=3 with a second start (len=9) while busy.
        mem_a[0] = 32'hFFFF_FFFF; mem_b[0] = 32'd2;
        mem_a[1] = 32'h1234_5678; mem_b[1] = 32'h1111_1111;
        mem_a[2] = 32'd100;       mem_b[2] = 32'd200;
        run(8'd3, 1'b1);

        // Zero operand A: written in the default build, skipped when enabled.
        mem_a[0] = 32'd0; mem_b[0] = 32'd9;
        mem_a[1] = 32'd3; mem_b[1] = 32'd4;
        run(8'd2, 1'b0);

        // Reset during WAIT of the second word of a len=4 job.
        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'd4;
        mem_b[0] = 32'd10; mem_b[1] = 32'd20; mem_b[2] = 32'd30; mem_b[3] = 32'd40;
        @(negedge clk);
        s = cyc;
        sb.push_back('{BASE_C, 32'd11, s + 4});
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy",   {31'd0, busy}, 32'd1);
        check("mid_addr_a", addr_a, BASE_A + 32'd4);
        check("mid_addr_b", addr_b, BASE_B + 32'd4);
        dc = done_cnt;
        reset = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_addr_a", addr_a, 32'd0);
        check("abort_addr_b", addr_b, 32'd0);
        check("abort_op_a",   op_a,   32'd0);
        check("abort_op_b",   op_b,   32'd0);
        check("abort_addr_c", addr_c, 32'd0);
        check("abort_din_c",  din_c,  32'd0);
        check("abort_we_c",   {28'd0, we_c}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_sb_drained", 32'(sb.size()), 32'd0);

        // Fresh job right on reset release must start from index 0.
        mem_a[0] = 32'd5; mem_b[0] = 32'd7;
        run(8'd1, 1'b0);

        // Full-length job: no index wrap across 255 words.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        run(8'd255, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
